// File: rtl/delay_integ_intra_pkg.sv
// Shared definitions for the delay-difference / delay-integration pair:
// lane geometry, delay range, FSM encoding and small lane helpers.
package delay_integ_intra_pkg;

  localparam int NUM_CHANNELS   = 16;   // samples per beat, lane 0 oldest
  localparam int DATA_WIDTH     = 20;   // Q16.4 two's-complement sample
  localparam int HIST_COLS      = 4;    // output beats kept as history
  localparam int FILL_BEATS     = 4;    // valid beats suppressed after a restart
  localparam int DELAY_MIN      = 16;
  localparam int DELAY_MAX      = 64;
  localparam int SEL_WIDTH      = 7;
  localparam int FILL_CNT_WIDTH = 3;
  localparam int BEAT_WIDTH     = NUM_CHANNELS * DATA_WIDTH;

  typedef logic [DATA_WIDTH-1:0]     sample_t;
  typedef logic [BEAT_WIDTH-1:0]     beat_t;
  typedef logic [SEL_WIDTH-1:0]      delay_t;
  typedef logic [FILL_CNT_WIDTH-1:0] fill_cnt_t;

  // Shared with delay_diff_intra; encoding is fixed so both blocks agree.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_t;

  // Extract one Q16.4 lane from a packed beat.
  function automatic sample_t lane_get(input beat_t beat, input int lane);
    return beat[lane*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // Saturate a requested delay into the supported range.
  function automatic delay_t clamp_delay(input delay_t sel);
    if (sel < delay_t'(DELAY_MIN)) return delay_t'(DELAY_MIN);
    if (sel > delay_t'(DELAY_MAX)) return delay_t'(DELAY_MAX);
    return sel;
  endfunction

  // True when a requested delay would be altered by clamp_delay.
  function automatic logic delay_out_of_range(input delay_t sel);
    return (sel < delay_t'(DELAY_MIN)) || (sel > delay_t'(DELAY_MAX));
  endfunction

endpackage

// File: rtl/delay_integ_hist.sv
// History store for the integrator: the last HIST_COLS reconstructed beats,
// shifted in on valid beats, clearable by sync/N change, plus the per-lane
// mux that picks x[s-N] for every lane of the current beat.
module delay_integ_hist
  import delay_integ_intra_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   shift_en,   // a valid beat is being written
  input  logic   clear,      // drop all history older than the incoming beat
  input  beat_t  new_beat,   // beat produced this cycle, becomes column 1
  input  delay_t n_sel,      // delay used for the lane mux
  output beat_t  src_beat    // x[s-N] for each lane of the current beat
);

  // hist_q[0] is column 1 (previous output beat), hist_q[HIST_COLS-1] the oldest.
  beat_t hist_q [HIST_COLS];

  // Shift history on valid beats; a clear zeroes everything behind the new beat.
  // NOTE: every flop here uses <= so all columns shift from their pre-edge
  // values; a blocking assignment would ripple new_beat through every column.
  // NOTE: the history is reset explicitly because zero history is the defined
  // starting condition that makes this block the exact inverse of the differencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < HIST_COLS; c++) hist_q[c] <= '0;
    end else if (shift_en) begin
      hist_q[0] <= new_beat;
      for (int c = 1; c < HIST_COLS; c++) hist_q[c] <= clear ? '0 : hist_q[c-1];
    end else if (clear) begin
      for (int c = 0; c < HIST_COLS; c++) hist_q[c] <= '0;
    end
  end

  // Lane k of sample s=16t+k looks back off=(15-k)+N samples from the newest
  // sample of the current beat: off[6:4] selects the column, off[3:0] counts
  // back from lane 15 within that column.
  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
    delay_t     off;
    logic [2:0] col;
    logic [3:0] row;
    sample_t    pick;

    assign off = delay_t'(NUM_CHANNELS - 1 - k) + n_sel;
    assign col = off[6:4];
    assign row = off[3:0];

    // Column/lane mux for this lane.
    // NOTE: pick gets a default before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
      pick = '0;
      for (int c = 0; c < HIST_COLS; c++) begin
        if (int'(col) == c + 1) pick = lane_get(hist_q[c], NUM_CHANNELS - 1 - int'(row));
      end
    end

    assign src_beat[k*DATA_WIDTH +: DATA_WIDTH] = pick;
  end

endmodule

// File: rtl/delay_integ_intra.sv
// 16-lane delay integrator: rebuilds x[s] = x[s-N] - diff[s] from the output
// of the delay-difference stage. Two-stage pipeline: S1 registers the inputs
// and the clamped delay, S2 applies the recurrence and registers the output.
module delay_integ_intra
  import delay_integ_intra_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_WIDTH-1:0]  delay_sel,
  input  logic                  sync_in,
  input  logic                  valid_in,
  input  logic [BEAT_WIDTH-1:0] diff_in,
  output logic [BEAT_WIDTH-1:0] recon_out,
  output logic                  valid_out,
  output logic                  sel_clamped
);

  // S1 registers
  logic   s1_valid;
  logic   s1_sync;
  beat_t  s1_diff;
  delay_t s1_n;

  // Control state
  fsm_state_t state_q, state_d;
  fill_cnt_t  fill_cnt_q, fill_cnt_d;
  delay_t     n_act_q, n_act_d;

  // S2 datapath
  logic  n_change;
  logic  zero_hist;
  logic  beat_live;
  beat_t src_beat;
  beat_t recon_beat;

  // S1: capture the beat, its control bits and the clamped delay; track clamping.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_sync     <= 1'b0;
      s1_diff     <= '0;
      s1_n        <= delay_t'(DELAY_MIN);
      sel_clamped <= 1'b0;
    end else begin
      s1_valid <= valid_in;
      s1_sync  <= sync_in;
      s1_diff  <= diff_in;
      s1_n     <= clamp_delay(delay_sel);
      if (valid_in && delay_out_of_range(delay_sel)) sel_clamped <= 1'b1;
    end
  end

  // A new delay or a sync means the beat must see zero history.
  assign n_change  = s1_valid && (s1_n != n_act_q);
  assign zero_hist = s1_sync || n_change;

  delay_integ_hist u_hist (
    .clk      (clk),
    .rst      (rst),
    .shift_en (s1_valid),
    .clear    (zero_hist),
    .new_beat (recon_beat),
    .n_sel    (s1_n),
    .src_beat (src_beat)
  );

  // Sixteen subtractors; the result wraps modulo 2^20 by construction.
  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_sub
    sample_t src_k;
    assign src_k = zero_hist ? '0 : lane_get(src_beat, k);
    assign recon_beat[k*DATA_WIDTH +: DATA_WIDTH] = src_k - lane_get(s1_diff, k);
  end

  // Next-state: fill counting, restart on sync / delay change, output qualification.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    n_act_d    = n_act_q;
    beat_live  = 1'b0;
    if (s1_valid) begin
      n_act_d = s1_n;
      if (zero_hist) begin
        state_d    = ST_FILL;
        fill_cnt_d = fill_cnt_t'(1);
      end else if (state_q == ST_FILL) begin
        fill_cnt_d = fill_cnt_q + fill_cnt_t'(1);
        if (fill_cnt_d == fill_cnt_t'(FILL_BEATS)) state_d = ST_RUN;
      end else begin
        beat_live = 1'b1;
      end
    end else if (s1_sync) begin
      state_d    = ST_FILL;
      fill_cnt_d = '0;
    end
  end

  // S2: control state and registered outputs; recon_out holds across gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FILL;
      fill_cnt_q <= '0;
      n_act_q    <= delay_t'(DELAY_MIN);
      valid_out  <= 1'b0;
      recon_out  <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      n_act_q    <= n_act_d;
      valid_out  <= beat_live;
      if (s1_valid) recon_out <= recon_beat;
    end
  end

endmodule

// File: tb/tb_delay_integ_intra.sv
// Self-checking bench for delay_integ_intra: a table of hand-computed
// uniform-lane vectors, then directed sequences checked against ramp values
// and a sample-level reference integrator.
module tb_delay_integ_intra;
  import delay_integ_intra_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  delay_t delay_sel;
  logic   sync_in;
  logic   valid_in;
  beat_t  diff_in;
  beat_t  recon_out;
  logic   valid_out;
  logic   sel_clamped;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  delay_integ_intra dut (
    .clk         (clk),
    .rst         (rst),
    .delay_sel   (delay_sel),
    .sync_in     (sync_in),
    .valid_in    (valid_in),
    .diff_in     (diff_in),
    .recon_out   (recon_out),
    .valid_out   (valid_out),
    .sel_clamped (sel_clamped)
  );

  task automatic check(input string name, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expectation of the previous step; its output appears one step later.
  logic  pend = 1'b0;
  logic  pend_v;
  beat_t pend_r;
  string pend_name;

  task automatic step(input logic v, input logic s, input delay_t sel, input beat_t d,
                      input logic ev, input beat_t er, input string name);
    @(negedge clk);
    valid_in  = v;
    sync_in   = s;
    delay_sel = sel;
    diff_in   = d;
    @(posedge clk);
    #1;
    if (pend) begin
      check({pend_name, " valid"}, beat_t'(valid_out), beat_t'(pend_v));
      check({pend_name, " recon"}, recon_out, pend_r);
    end
    pend      = 1'b1;
    pend_v    = ev;
    pend_r    = er;
    pend_name = name;
  endtask

  // Sample-level reference: x[s] = x[s-N] - diff[s], history since last restart.
  sample_t ref_y [8192];
  int      ref_len;
  delay_t  ref_n;
  beat_t   ref_last;

  function automatic delay_t ref_clamp(input delay_t sel);
    if (sel < 7'd16) return 7'd16;
    if (sel > 7'd64) return 7'd64;
    return sel;
  endfunction

  task automatic model_reset();
    ref_len  = 0;
    ref_n    = 7'd16;
    ref_last = '0;
  endtask

  task automatic model_beat(input logic v, input logic s, input delay_t sel, input beat_t d,
                            output logic ev, output beat_t er);
    delay_t  n;
    logic    restart;
    int      idx;
    sample_t prev;
    er = ref_last;
    ev = 1'b0;
    if (!v) begin
      if (s) ref_len = 0;
      return;
    end
    n       = ref_clamp(sel);
    restart = s || (n != ref_n);
    if (restart) ref_len = 0;
    ref_n = n;
    ev    = (ref_len >= 4 * 16);
    for (int k = 0; k < 16; k++) begin
      idx  = ref_len + k;
      prev = (idx >= int'(n)) ? ref_y[idx - int'(n)] : 20'h0;
      ref_y[idx] = prev - d[k*20 +: 20];
      er[k*20 +: 20] = ref_y[idx];
    end
    ref_len  = ref_len + 16;
    ref_last = er;
  endtask

  task automatic mstep(input logic v, input logic s, input delay_t sel, input beat_t d,
                       input string name);
    logic  ev;
    beat_t er;
    model_beat(v, s, sel, d, ev, er);
    step(v, s, sel, d, ev, er, name);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst      = 1'b1;
    valid_in = 1'b0;
    sync_in  = 1'b0;
    diff_in  = '0;
    @(posedge clk);
    #1;
    check({name, " valid_out"}, beat_t'(valid_out), '0);
    check({name, " recon_out"}, recon_out, '0);
    check({name, " sel_clamped"}, beat_t'(sel_clamped), '0);
    pend = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    for (int k = 0; k < 16; k++) b[k*20 +: 20] = 20'($urandom);
    return b;
  endfunction

  typedef struct {
    logic    v;
    logic    s;
    delay_t  sel;
    sample_t d;
    logic    ev;
    sample_t er;
  } vec_t;

  vec_t tbl [19];

  initial begin
    logic  dv;
    beat_t dr;
    beat_t d;
    beat_t exp_r;
    int    smp;

    // Uniform-lane vectors at N=16: recon lane k of beat t = previous beat lane k - diff.
    tbl[0]  = '{1'b1, 1'b0, 7'd16, 20'hFFFFF, 1'b0, 20'h00001};
    tbl[1]  = '{1'b1, 1'b0, 7'd16, 20'hFFFFF, 1'b0, 20'h00002};
    tbl[2]  = '{1'b1, 1'b0, 7'd16, 20'hFFFFF, 1'b0, 20'h00003};
    tbl[3]  = '{1'b1, 1'b0, 7'd16, 20'hFFFFF, 1'b0, 20'h00004};
    tbl[4]  = '{1'b1, 1'b0, 7'd16, 20'hFFFFF, 1'b1, 20'h00005};
    tbl[5]  = '{1'b0, 1'b0, 7'd16, 20'h00000, 1'b0, 20'h00005};
    tbl[6]  = '{1'b1, 1'b0, 7'd16, 20'hFFFFF, 1'b1, 20'h00006};
    tbl[7]  = '{1'b1, 1'b0, 7'd16, 20'h80008, 1'b1, 20'h7FFFE};
    tbl[8]  = '{1'b1, 1'b0, 7'd16, 20'hFFFFF, 1'b1, 20'h7FFFF};
    tbl[9]  = '{1'b1, 1'b0, 7'd16, 20'hFFFFF, 1'b1, 20'h80000};
    tbl[10] = '{1'b1, 1'b0, 7'd16, 20'hFFFFF, 1'b1, 20'h80001};
    tbl[11] = '{1'b1, 1'b0, 7'd16, 20'h00001, 1'b1, 20'h80000};
    tbl[12] = '{1'b1, 1'b1, 7'd16, 20'hFFFFF, 1'b0, 20'h00001};
    tbl[13] = '{1'b1, 1'b0, 7'd16, 20'hFFFFF, 1'b0, 20'h00002};
    tbl[14] = '{1'b1, 1'b0, 7'd16, 20'hFFFFF, 1'b0, 20'h00003};
    tbl[15] = '{1'b1, 1'b0, 7'd16, 20'hFFFFF, 1'b0, 20'h00004};
    tbl[16] = '{1'b1, 1'b0, 7'd16, 20'hFFFFF, 1'b1, 20'h00005};
    tbl[17] = '{1'b1, 1'b0, 7'd5,  20'hFFFFF, 1'b1, 20'h00006};
    tbl[18] = '{1'b0, 1'b0, 7'd16, 20'h00000, 1'b0, 20'h00006};

    rst       = 1'b1;
    valid_in  = 1'b0;
    sync_in   = 1'b0;
    delay_sel = 7'd16;
    diff_in   = '0;
    model_reset();

    do_reset("reset0");

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].sel, {NUM_CHANNELS{tbl[i].d}},
           tbl[i].ev, {NUM_CHANNELS{tbl[i].er}}, $sformatf("tbl[%0d]", i));
    end
    step(1'b0, 1'b0, 7'd16, '0, 1'b0, {NUM_CHANNELS{20'h00006}}, "tbl idle");
    check("clamp low sticky", beat_t'(sel_clamped), beat_t'(1));

    // Round trip of a ramp x=s through a zero-primed N=20 differencer.
    do_reset("reset1");
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 16; k++) begin
        smp = 16 * t + k;
        d[k*20 +: 20]     = 20'((smp >= 20 ? smp - 20 : 0) - smp);
        exp_r[k*20 +: 20] = 20'(smp);
      end
      model_beat(1'b1, 1'b0, 7'd20, d, dv, dr);
      step(1'b1, 1'b0, 7'd20, d, (t >= 4), exp_r, $sformatf("ramp t=%0d", t));
    end

    // Delay change 20 -> 48 mid-run: four suppressed beats, then N=48 output.
    for (int t = 0; t < 10; t++) mstep(1'b1, 1'b0, 7'd48, rand_beat(), $sformatf("n48 t=%0d", t));
    check("no clamp in range", beat_t'(sel_clamped), '0);

    // Gaps at N=32: valid pattern 1,0,0,1; idle cycles carry junk.
    for (int i = 0; i < 24; i++) begin
      if ((i % 4 == 0) || (i % 4 == 3)) mstep(1'b1, 1'b0, 7'd32, rand_beat(), $sformatf("gap i=%0d", i));
      else mstep(1'b0, 1'b0, 7'd50, rand_beat(), $sformatf("gap idle i=%0d", i));
    end

    // Sync without valid in RUN: history cleared and fill restarts.
    mstep(1'b0, 1'b1, 7'd32, rand_beat(), "sync idle");
    for (int t = 0; t < 6; t++) mstep(1'b1, 1'b0, 7'd32, rand_beat(), $sformatf("post sync t=%0d", t));

    // Oversized delay runs as 64.
    for (int t = 0; t < 8; t++) mstep(1'b1, 1'b0, 7'd90, rand_beat(), $sformatf("n90 t=%0d", t));
    mstep(1'b0, 1'b0, 7'd64, '0, "n90 idle");
    check("clamp high sticky", beat_t'(sel_clamped), beat_t'(1));

    // Reset during RUN at beat 10, then an impulse against zero history.
    for (int t = 0; t < 10; t++) mstep(1'b1, 1'b0, 7'd16, rand_beat(), $sformatf("pre rst t=%0d", t));
    do_reset("reset2");
    d = '0;
    d[19:0] = 20'h00001;
    mstep(1'b1, 1'b0, 7'd16, d, "impulse t=0");
    for (int t = 1; t < 7; t++) mstep(1'b1, 1'b0, 7'd16, '0, $sformatf("impulse t=%0d", t));
    mstep(1'b0, 1'b0, 7'd16, '0, "impulse idle");
    check("impulse lane0", beat_t'(recon_out[19:0]), beat_t'(20'hFFFFF));
    mstep(1'b0, 1'b0, 7'd16, '0, "final idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
